// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_pkg
//  Description : Shared pipeline definitions: hazard-FSM state encoding and
//                the hard-wired zero register index.
//  Revision    : 1.0  initial release
// ============================================================================
package pipeline_pkg;

    // Hazard controller state; RUN must encode as 0 so reset lands in RUN.
    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    // x0 is hard-wired to zero, so a write to it never creates a dependency.
    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage : pipeline_pkg
`default_nettype wire

// File: rtl/hazard_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_controller_if
//  Description : Bundle between the pipeline datapath and the hazard
//                controller.
//  Ports (slave = hazard controller view):
//    in : MemRead_IDEX_i, rd_IDEX_i, rs1_IFID_i, rs2_IFID_i, use_rs1_i,
//         use_rs2_i, branch_taken_i, dmem_req_i, dmem_ready_i
//    out: PCWrite_o, IFIDWrite_o, IDEXWrite_o, EXMEWrite_o, MEWBWrite_o,
//         IFID_flush_o, IDEX_flush_o, stall_cnt_o[CNT_W], mem_timeout_o
//  Revision    : 1.0  initial release
// ============================================================================
interface hazard_controller_if #(
    parameter int CNT_W = 16
);
    logic             MemRead_IDEX_i;
    logic [4:0]       rd_IDEX_i;
    logic [4:0]       rs1_IFID_i;
    logic [4:0]       rs2_IFID_i;
    logic             use_rs1_i;
    logic             use_rs2_i;
    logic             branch_taken_i;
    logic             dmem_req_i;
    logic             dmem_ready_i;

    logic             PCWrite_o;
    logic             IFIDWrite_o;
    logic             IDEXWrite_o;
    logic             EXMEWrite_o;
    logic             MEWBWrite_o;
    logic             IFID_flush_o;
    logic             IDEX_flush_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic             mem_timeout_o;

    // Pipeline side: drives the hazard inputs, consumes the controls.
    modport master (
        output MemRead_IDEX_i, rd_IDEX_i, rs1_IFID_i, rs2_IFID_i,
               use_rs1_i, use_rs2_i, branch_taken_i, dmem_req_i, dmem_ready_i,
        input  PCWrite_o, IFIDWrite_o, IDEXWrite_o, EXMEWrite_o, MEWBWrite_o,
               IFID_flush_o, IDEX_flush_o, stall_cnt_o, mem_timeout_o
    );

    // Hazard controller side.
    modport slave (
        input  MemRead_IDEX_i, rd_IDEX_i, rs1_IFID_i, rs2_IFID_i,
               use_rs1_i, use_rs2_i, branch_taken_i, dmem_req_i, dmem_ready_i,
        output PCWrite_o, IFIDWrite_o, IDEXWrite_o, EXMEWrite_o, MEWBWrite_o,
               IFID_flush_o, IDEX_flush_o, stall_cnt_o, mem_timeout_o
    );
endinterface : hazard_controller_if
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter that sticks at all-ones instead of wrapping.
//  Ports       : clk, rst_n (async, active-low), inc_i, clear_i,
//                count_o[WIDTH]
//  Revision    : 1.0  initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             inc_i,
    input  wire logic             clear_i,
    output logic      [WIDTH-1:0] count_o
);
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
endmodule : sat_counter
`default_nettype wire

// File: rtl/hazard_controller.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_controller
//  Description : Pipeline hazard unit. Freezes all stages while data memory
//                is busy, flushes IF/ID and ID/EX on a taken branch, inserts
//                a one-cycle bubble on a load-use dependency, counts stall
//                cycles and flags an over-long memory wait.
//  Ports       : clk, rst_n (async, active-low), hz (hazard_controller_if
//                slave: hazard inputs in, stage enables/flushes/status out)
//  Revision    : 1.0  initial release
// ============================================================================
module hazard_controller
    import pipeline_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 16
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    hazard_controller_if.slave hz
);
    localparam int              WAIT_W      = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [WAIT_W-1:0] TIMEOUT_LIM = WAIT_W'(TIMEOUT_CYC);

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q,  wait_d;
    logic              timeout_q, timeout_d;

    logic       w_mem_busy;
    logic       w_mem_stall;
    logic       w_load_use;
    logic       w_pc_we;
    logic       w_ifid_we;
    logic       w_back_we;      // ID/EX, EX/MEM and MEM/WB move together
    logic       w_ifid_flush;
    logic       w_idex_flush;
    logic [CNT_W-1:0] w_stall_cnt;

    assign w_mem_busy = hz.dmem_req_i && !hz.dmem_ready_i;
    // Once waiting, only dmem_ready_i releases the pipeline.
    assign w_mem_stall = w_mem_busy || ((state_q == MEM_WAIT) && !hz.dmem_ready_i);

    assign w_load_use = hz.MemRead_IDEX_i && (hz.rd_IDEX_i != REG_ZERO) &&
                        ((hz.use_rs1_i && (hz.rs1_IFID_i == hz.rd_IDEX_i)) ||
                         (hz.use_rs2_i && (hz.rs2_IFID_i == hz.rd_IDEX_i)));

    always_comb begin
        state_d      = RUN;
        wait_d       = '0;
        timeout_d    = timeout_q;
        w_pc_we      = 1'b1;
        w_ifid_we    = 1'b1;
        w_back_we    = 1'b1;
        w_ifid_flush = 1'b0;
        w_idex_flush = 1'b0;

        if (w_mem_stall) begin
            w_pc_we   = 1'b0;
            w_ifid_we = 1'b0;
            w_back_we = 1'b0;
            state_d   = MEM_WAIT;
            // Entry cycle from RUN is not a wait cycle; the count starts at 0.
            if (state_q == MEM_WAIT) begin
                wait_d = (wait_q == TIMEOUT_LIM) ? wait_q : wait_q + 1'b1;
                if (wait_d == TIMEOUT_LIM) begin
                    timeout_d = 1'b1;
                end
            end
        end else if (hz.branch_taken_i) begin
            w_ifid_flush = 1'b1;
            w_idex_flush = 1'b1;
        end else if (w_load_use) begin
            w_pc_we      = 1'b0;
            w_ifid_we    = 1'b0;
            w_idex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

    // Ungated enable drives the counter; its flop is held by reset anyway.
    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (!w_pc_we),
        .clear_i (1'b0),
        .count_o (w_stall_cnt)
    );

    // Outputs forced low for the whole time reset is asserted.
    assign hz.PCWrite_o     = rst_n && w_pc_we;
    assign hz.IFIDWrite_o   = rst_n && w_ifid_we;
    assign hz.IDEXWrite_o   = rst_n && w_back_we;
    assign hz.EXMEWrite_o   = rst_n && w_back_we;
    assign hz.MEWBWrite_o   = rst_n && w_back_we;
    assign hz.IFID_flush_o  = rst_n && w_ifid_flush;
    assign hz.IDEX_flush_o  = rst_n && w_idex_flush;
    assign hz.stall_cnt_o   = w_stall_cnt;
    assign hz.mem_timeout_o = timeout_q;
endmodule : hazard_controller
`default_nettype wire

// File: tb/tb_hazard_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_controller
//  Description : Scoreboard bench for hazard_controller: stimulus pushes the
//                reference model's expected outputs per cycle, a monitor pops
//                and compares at the falling edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hazard_controller;
    localparam int T_CYC   = 8;
    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    typedef struct {
        bit [4:0] en;      // {PC, IFID, IDEX, EXME, MEWB}
        bit [1:0] fl;      // {IFID_flush, IDEX_flush}
        int       cnt;
        bit       to;
    } exp_t;

    logic clk;
    logic rst_n;

    hazard_controller_if #(.CNT_W(CW)) bus ();

    hazard_controller #(
        .TIMEOUT_CYC (T_CYC),
        .CNT_W       (CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_push   = 0;
    int   n_pop    = 0;

    // Reference model state
    bit m_wait  = 0;   // waiting on memory
    int m_wcnt  = 0;   // wait cycles seen
    int m_stall = 0;   // stall cycles counted
    bit m_to    = 0;   // timeout seen

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_pop++;
            check("enables", int'({bus.PCWrite_o, bus.IFIDWrite_o, bus.IDEXWrite_o,
                                   bus.EXMEWrite_o, bus.MEWBWrite_o}), int'(e.en));
            check("flushes", int'({bus.IFID_flush_o, bus.IDEX_flush_o}), int'(e.fl));
            check("stall_cnt", int'(bus.stall_cnt_o), e.cnt);
            check("mem_timeout", int'(bus.mem_timeout_o), int'(e.to));
        end
    end

    // One clock cycle: apply inputs, predict, push, then advance the model.
    task automatic step(input bit rn, input bit mr, input int rd, input int rs1,
                        input int rs2, input bit u1, input bit u2, input bit br,
                        input bit req, input bit rdy);
        exp_t e;
        bit   lu, mstall;
        rst_n                 = rn;
        bus.MemRead_IDEX_i    = mr;
        bus.rd_IDEX_i         = 5'(rd);
        bus.rs1_IFID_i        = 5'(rs1);
        bus.rs2_IFID_i        = 5'(rs2);
        bus.use_rs1_i         = u1;
        bus.use_rs2_i         = u2;
        bus.branch_taken_i    = br;
        bus.dmem_req_i        = req;
        bus.dmem_ready_i      = rdy;

        if (!rn) begin
            m_wait = 0; m_wcnt = 0; m_stall = 0; m_to = 0;
        end
        lu     = mr && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        mstall = !rdy && (req || m_wait);

        if (!rn)         begin e.en = 5'b00000; e.fl = 2'b00; end
        else if (mstall) begin e.en = 5'b00000; e.fl = 2'b00; end
        else if (br)     begin e.en = 5'b11111; e.fl = 2'b11; end
        else if (lu)     begin e.en = 5'b00111; e.fl = 2'b01; end
        else             begin e.en = 5'b11111; e.fl = 2'b00; end
        e.cnt = m_stall;
        e.to  = m_to;
        exp_q.push_back(e);
        n_push++;

        @(posedge clk);
        if (rn) begin
            if (!e.en[4]) m_stall = (m_stall < CNT_MAX) ? m_stall + 1 : CNT_MAX;
            if (m_wait && !rdy) begin
                m_wcnt = (m_wcnt < T_CYC) ? m_wcnt + 1 : T_CYC;
                if (m_wcnt == T_CYC) m_to = 1;
            end else begin
                m_wcnt = 0;
            end
            m_wait = mstall;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        rst_n = 0;
        bus.MemRead_IDEX_i = 0; bus.rd_IDEX_i = 0; bus.rs1_IFID_i = 0;
        bus.rs2_IFID_i = 0; bus.use_rs1_i = 0; bus.use_rs2_i = 0;
        bus.branch_taken_i = 0; bus.dmem_req_i = 0; bus.dmem_ready_i = 1;
        @(posedge clk); #1;

        do_reset();
        idle(2);
        // load-use via rs1, one cycle
        step(1, 1, 5, 5, 0, 1, 0, 0, 0, 1);
        idle(2);
        // rd == x0 and rs1 not used: no stall
        step(1, 1, 0, 0, 0, 1, 1, 0, 0, 1);
        step(1, 1, 5, 5, 0, 0, 0, 0, 0, 1);
        // load-use via rs2
        step(1, 1, 7, 1, 7, 0, 1, 0, 0, 1);
        // load-use with taken branch
        step(1, 1, 5, 5, 0, 1, 0, 1, 0, 1);
        idle(1);

        // memory wait: 4 busy cycles then ready
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(1, 1, 3, 3, 0, 1, 0, 0, 1, 1);   // release, load-use evaluated
        idle(2);

        // timeout: 10 busy cycles, release, then reset mid-wait
        do_reset();
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        idle(2);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);   // reset aborts the wait
        idle(2);

        // saturation: 20 load-use cycles
        for (int i = 0; i < 20; i++) step(1, 1, 9, 9, 9, 1, 1, 0, 0, 1);
        idle(2);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 59) != 0),
                 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 2) != 0));
        end
        idle(1);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        check("scoreboard_drained", n_pop, n_push);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule : tb_hazard_controller
`default_nettype wire
